memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline M stage; sits directly after the execute stage and consumes its M-side outputs (RegWriteM, MemWriteM, ResultSrcM, RDM, WriteDataM, ALUResultM).
- Drives a request/grant data-memory bus for loads and stores.
- Stalls upstream while a memory transaction is outstanding.
- Registers results into the M/W pipeline register for writeback.
- Bounds every bus transaction with a timeout that reports a bus error.

Parameters:
DATA_W, 19, datapath width
REG_W, 5, register-address width
ADDR_W, 15, memory address width; MemAddr = ALUResultM[ADDR_W-1:0]
TIMEOUT, 16, max cycles a transaction may wait for grant or read data (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
RegWriteM  in  1  instruction writes a register
MemWriteM  in  1  instruction is a store
ResultSrcM  in  2  result select; 2'b01 = load
RDM  in  REG_W  destination register
WriteDataM  in  DATA_W  store data
ALUResultM  in  DATA_W  address / ALU result
MemReq  out  1  bus request
MemWe  out  1  1 = write, 0 = read; valid while MemReq=1
MemAddr  out  ADDR_W  bus address
MemWData  out  DATA_W  bus write data
MemGnt  in  1  bus accepted request this cycle
MemRValid  in  1  read data valid
MemRData  in  DATA_W  read data
StallM  out  1  M instruction cannot retire; upstream holds M inputs stable
RegWriteW  out  1  registered to W
ResultSrcW  out  2  registered to W
RDW  out  REG_W  registered to W
ALUResultW  out  DATA_W  registered to W
ReadDataW  out  DATA_W  load data to W
BusErrW  out  1  retired instruction timed out

Behaviour:
Reset:
- reset=0: state=IDLE, timeout counter=0.
- All W outputs are 0.
- MemReq, MemWe and StallM are forced 0 asynchronously.
- Reset mid-transaction abandons the transaction; a late MemRValid after reset is ignored.

Operation decode:
- Load = ResultSrcM==01 && !MemWriteM.
- Store = MemWriteM.
- MemWriteM && ResultSrcM==01 is treated as a store; ReadDataW=0 on retire.

States:
- IDLE: no outstanding transaction.
- REQ: MemReq held high awaiting MemGnt.
- WAIT_RD: read granted, awaiting MemRValid.

IDLE:
- Non-memory op: retire same cycle, StallM=0, 1-cycle latency to W.
- Memory op: MemReq=1 combinationally; MemWe, MemAddr and MemWData are driven from the M inputs.
  - Store with MemGnt=1: retire, StallM=0.
  - Load with MemGnt=1 and MemRValid=1: retire, capture MemRData.
  - Load with MemGnt=1 only: go to WAIT_RD, StallM=1.
  - No grant: go to REQ, StallM=1.

REQ:
- MemReq=1 and StallM=1 until MemGnt.
- On grant, same rules as IDLE: a store or a zero-wait load retires; otherwise go to WAIT_RD.

WAIT_RD:
- MemReq=0, StallM=1.
- On MemRValid: capture MemRData, retire (StallM=0 that cycle), return to IDLE.

Timeout:
- Counter clears on entering REQ or WAIT_RD and increments each cycle in those states.
- At count==TIMEOUT-1 with no grant/valid: force retire, ReadDataW=0, BusErrW=1, MemReq drops, state=IDLE.
- If MemGnt/MemRValid arrives in the same cycle as the timeout, the handshake wins; no error.

W register:
- On retire: capture RegWriteM, ResultSrcM, RDM, ALUResultM, read data, and the error flag.
- On any stalled cycle: bubble with RegWriteW=0 and BusErrW=0; other W fields hold their values.
- A timed-out load still writes back (RegWriteW=RegWriteM) with data 0.
- BusErrW is a one-cycle pulse.

Other rules:
- MemRValid outside WAIT_RD (or outside the grant cycle of a load) is ignored.
- Back-to-back memory ops: a new request may issue in the cycle after retire, with no dead cycle required.

Decomposition:
- Package `memory_stage_pkg`:
  - DATA_W/REG_W defaults
  - ResultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10
  - state enum mem_state_t {IDLE, REQ, WAIT_RD}
- One sub-module, `mem_bus_fsm`: the state machine, timeout counter, MemReq/StallM generation and retire/error strobes.
- The top level holds the W pipeline register and bus datapath muxing.

Test Plan:
1. ALU op: RegWriteM=1, ResultSrcM=00, RDM=5, ALUResultM=0x00123 → next cycle RegWriteW=1, RDW=5, ALUResultW=0x00123; StallM stays 0; MemReq stays 0.
2. Zero-wait store: MemWriteM=1, ALUResultM=0x0040, WriteDataM=0x7ABCD, MemGnt=1 → same cycle MemReq=1, MemWe=1, MemAddr=0x0040, MemWData=0x7ABCD, StallM=0; next cycle RegWriteW=0.
3. Load with 2-cycle grant delay and 3-cycle data delay, MemRData=0x1F00F, RDM=9:
   - StallM=1 for 5 cycles.
   - Bubbles have RegWriteW=0.
   - Then RDW=9, ReadDataW=0x1F00F, ResultSrcW=01, BusErrW=0.
4. Load, MemGnt=1, MemRValid never asserted, TIMEOUT=16:
   - Retire exactly 16 cycles after entering WAIT_RD.
   - ReadDataW=0, BusErrW=1 for one cycle, then back to IDLE.
5. Load in WAIT_RD, reset pulsed low 1 cycle:
   - MemReq=0, StallM=0 and all W outputs 0 immediately.
   - A subsequent MemRValid=1 with 0x12345 has no effect on ReadDataW.
6. Simultaneous MemRValid and timeout at count TIMEOUT-1 → data 0x00055 captured, BusErrW=0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types and defaults for the memory (M) pipeline stage.
package memory_stage_pkg;

    localparam int DATA_W_DEF  = 19;
    localparam int REG_W_DEF   = 5;
    localparam int ADDR_W_DEF  = 15;
    localparam int TIMEOUT_DEF = 16;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_bus_fsm.sv
// Request/grant bus sequencer for the M stage: state, timeout counter,
// request/stall generation and retire/error strobes.
module mem_bus_fsm
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_op_i,
    input  logic       is_load_i,
    input  logic       gnt_i,
    input  logic       rvalid_i,
    output logic       req_o,
    output logic       stall_o,
    output logic       retire_o,
    output logic       rd_take_o,
    output logic       bus_err_o,
    output mem_state_t state_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    logic             req, retire, rd_take, bus_err;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        req     = 1'b0;
        retire  = 1'b0;
        rd_take = 1'b0;
        bus_err = 1'b0;
        unique case (state_q)
            IDLE, REQ: begin
                if (state_q == IDLE && !mem_op_i) begin
                    retire = 1'b1;
                end else begin
                    req = 1'b1;
                    if (gnt_i) begin
                        // Grant with no read outstanding (store, or load with data in the same cycle).
                        if (!is_load_i || rvalid_i) begin
                            retire  = 1'b1;
                            rd_take = is_load_i;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_RD;
                            cnt_d   = '0;
                        end
                    end else if (state_q == IDLE) begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end else if (timeout) begin
                        retire  = 1'b1;
                        bus_err = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RD: begin
                if (rvalid_i) begin
                    retire  = 1'b1;
                    rd_take = 1'b1;
                    state_d = IDLE;
                end else if (timeout) begin
                    retire  = 1'b1;
                    bus_err = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus-facing strobes are masked while reset is low so nothing leaks onto the bus.
    assign req_o     = reset & req;
    assign stall_o   = reset & ~retire;
    assign retire_o  = retire;
    assign rd_take_o = rd_take;
    assign bus_err_o = bus_err;
    assign state_o   = state_q;

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: drives the data-memory bus and holds the M/W register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [REG_W-1:0]  RDM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALUResultM,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemGnt,
    input  logic              MemRValid,
    input  logic [DATA_W-1:0] MemRData,
    output logic              StallM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [REG_W-1:0]  RDW,
    output logic [DATA_W-1:0] ALUResultW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic              BusErrW
);

    logic       is_load, is_store, mem_op;
    logic       retire, rd_take, bus_err;
    mem_state_t bus_state;

    // A store with ResultSrc=load still decodes as a store.
    assign is_store = MemWriteM;
    assign is_load  = (ResultSrcM == RES_MEM) && !MemWriteM;
    assign mem_op   = is_store | is_load;

    mem_bus_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .mem_op_i (mem_op),
        .is_load_i(is_load),
        .gnt_i    (MemGnt),
        .rvalid_i (MemRValid),
        .req_o    (MemReq),
        .stall_o  (StallM),
        .retire_o (retire),
        .rd_take_o(rd_take),
        .bus_err_o(bus_err),
        .state_o  (bus_state)
    );

    assign MemWe    = MemReq && is_store && (bus_state != WAIT_RD);
    assign MemAddr  = ALUResultM[ADDR_W-1:0];
    assign MemWData = WriteDataM;

    // Stalled cycles push a bubble: only the write enable and error flag are cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            RDW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            BusErrW    <= 1'b0;
        end else if (retire) begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= rd_take ? MemRData : '0;
            BusErrW    <= bus_err;
        end else begin
            RegWriteW  <= 1'b0;
            BusErrW    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

    localparam int DATA_W = 19;
    localparam int REG_W  = 5;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              RegWriteM, MemWriteM;
    logic [1:0]        ResultSrcM;
    logic [REG_W-1:0]  RDM;
    logic [DATA_W-1:0] WriteDataM, ALUResultM;
    logic              MemReq, MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemGnt, MemRValid;
    logic [DATA_W-1:0] MemRData;
    logic              StallM, RegWriteW, BusErrW;
    logic [1:0]        ResultSrcW;
    logic [REG_W-1:0]  RDW;
    logic [DATA_W-1:0] ALUResultW, ReadDataW;

    int checks = 0;
    int errors = 0;

    memory_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RDM(RDM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemGnt(MemGnt), .MemRValid(MemRValid), .MemRData(MemRData),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RDW(RDW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] alu);
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = rs;
        RDM        = rd;
        WriteDataM = wd;
        ALUResultM = alu;
    endtask

    task automatic bus(input logic g, input logic v, input logic [DATA_W-1:0] d);
        MemGnt    = g;
        MemRValid = v;
        MemRData  = d;
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, "_regw"}, RegWriteW, 0);
        chk({tag, "_rs"}, ResultSrcW, 0);
        chk({tag, "_rd"}, RDW, 0);
        chk({tag, "_alu"}, ALUResultW, 0);
        chk({tag, "_rdata"}, ReadDataW, 0);
        chk({tag, "_err"}, BusErrW, 0);
    endtask

    initial begin
        // Reset with a pending load on the inputs: bus and stall must stay low.
        drive(1, 0, 2'b01, 5'd4, '0, 19'h00010);
        bus(0, 0, '0);
        #3;
        chk("rst_req", MemReq, 0);
        chk("rst_stall", StallM, 0);
        chk_w_zero("rst_w");
        drive(0, 0, 2'b00, '0, '0, '0);
        tick();
        reset = 1'b1;

        // 1. ALU op
        drive(1, 0, 2'b00, 5'd5, '0, 19'h00123);
        #4;
        chk("alu_stall", StallM, 0);
        chk("alu_req", MemReq, 0);
        tick();
        chk("alu_regw", RegWriteW, 1);
        chk("alu_rd", RDW, 5);
        chk("alu_res", ALUResultW, 19'h00123);
        chk("alu_rdata", ReadDataW, 0);

        // 2. Zero-wait store
        drive(0, 1, 2'b00, 5'd0, 19'h7ABCD, 19'h00040);
        bus(1, 0, '0);
        #4;
        chk("st_req", MemReq, 1);
        chk("st_we", MemWe, 1);
        chk("st_addr", MemAddr, 15'h0040);
        chk("st_wdata", MemWData, 19'h7ABCD);
        chk("st_stall", StallM, 0);
        tick();
        chk("st_regw", RegWriteW, 0);
        chk("st_err", BusErrW, 0);

        // 3. Load: grant after 2 cycles, data 3 cycles after grant
        drive(1, 0, 2'b01, 5'd9, '0, 19'h00100);
        for (int i = 0; i < 6; i++) begin
            bus(i == 2, i == 5, (i == 5) ? 19'h1F00F : 19'h0);
            #4;
            chk($sformatf("ld_stall%0d", i), StallM, (i < 5) ? 1 : 0);
            chk($sformatf("ld_req%0d", i), MemReq, (i <= 2) ? 1 : 0);
            if (i > 0) chk($sformatf("ld_bubble%0d", i), RegWriteW, 0);
            tick();
        end
        chk("ld_regw", RegWriteW, 1);
        chk("ld_rd", RDW, 9);
        chk("ld_rdata", ReadDataW, 19'h1F00F);
        chk("ld_rs", ResultSrcW, 2'b01);
        chk("ld_err", BusErrW, 0);
        chk("ld_alu", ALUResultW, 19'h00100);

        // Store flagged as load-result, then zero-wait load, back to back
        drive(0, 1, 2'b01, 5'd1, 19'h00011, 19'h00011);
        bus(1, 1, 19'h2AAAA);
        #4;
        chk("stl_we", MemWe, 1);
        chk("stl_stall", StallM, 0);
        tick();
        chk("stl_rdata", ReadDataW, 0);
        chk("stl_rs", ResultSrcW, 2'b01);
        drive(1, 0, 2'b01, 5'd12, '0, 19'h00022);
        bus(1, 1, 19'h0ABCD);
        #4;
        chk("b2b_req", MemReq, 1);
        chk("b2b_we", MemWe, 0);
        chk("b2b_stall", StallM, 0);
        tick();
        chk("b2b_rdata", ReadDataW, 19'h0ABCD);
        chk("b2b_rd", RDW, 12);

        // 4. Load granted, data never arrives: timeout after 16 WAIT_RD cycles
        drive(1, 0, 2'b01, 5'd3, '0, 19'h00200);
        bus(1, 0, '0);
        tick();
        bus(0, 0, '0);
        for (int k = 0; k < 16; k++) begin
            #4;
            chk($sformatf("to_stall%0d", k), StallM, (k == 15) ? 0 : 1);
            tick();
        end
        chk("to_err", BusErrW, 1);
        chk("to_rdata", ReadDataW, 0);
        chk("to_regw", RegWriteW, 1);
        chk("to_rd", RDW, 3);
        drive(0, 0, 2'b00, '0, '0, '0);
        #4;
        chk("to_idle_req", MemReq, 0);
        tick();
        chk("to_pulse", BusErrW, 0);

        // Store never granted: timeout in REQ
        drive(0, 1, 2'b00, 5'd2, 19'h00007, 19'h00300);
        bus(0, 0, '0);
        for (int k = 0; k < 17; k++) begin
            #4;
            chk($sformatf("rq_stall%0d", k), StallM, (k == 16) ? 0 : 1);
            chk($sformatf("rq_req%0d", k), MemReq, 1);
            tick();
        end
        chk("rq_err", BusErrW, 1);
        chk("rq_regw", RegWriteW, 0);

        // 6. Data arrives in the timeout cycle: handshake wins
        drive(1, 0, 2'b01, 5'd6, '0, 19'h00400);
        bus(1, 0, '0);
        tick();
        for (int k = 0; k < 16; k++) begin
            bus(0, k == 15, (k == 15) ? 19'h00055 : 19'h0);
            tick();
        end
        chk("race_rdata", ReadDataW, 19'h00055);
        chk("race_err", BusErrW, 0);
        chk("race_regw", RegWriteW, 1);

        // 5. Reset pulse during WAIT_RD
        drive(1, 0, 2'b01, 5'd7, '0, 19'h00300);
        bus(1, 0, '0);
        tick();
        bus(0, 0, '0);
        tick();
        reset = 1'b0;
        #1;
        chk("mrst_req", MemReq, 0);
        chk("mrst_stall", StallM, 0);
        chk_w_zero("mrst_w");
        tick();
        reset = 1'b1;
        drive(0, 0, 2'b00, '0, '0, '0);
        bus(0, 1, 19'h12345);
        #4;
        chk("mrst_stall2", StallM, 0);
        tick();
        chk("mrst_rdata", ReadDataW, 0);
        chk("mrst_err", BusErrW, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
